// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, clear and status bundle for the register file
interface regfile_mp_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 6,
    parameter int NR    = 2
);
    logic                  En;
    logic [NR*AW-1:0]      Read_reg;
    logic [NR*WIDTH-1:0]   Read_data;
    logic                  We0, We1;
    logic [AW-1:0]         Wa0, Wa1;
    logic [WIDTH-1:0]      Wd0, Wd1;
    logic                  Clr;
    logic                  Busy;
    logic                  Err;

    modport master (
        output En, Read_reg, We0, We1, Wa0, Wa1, Wd0, Wd1, Clr,
        input  Read_data, Busy, Err
    );

    modport slave (
        input  En, Read_reg, We0, We1, Wa0, Wa1, Wd0, Wd1, Clr,
        output Read_data, Busy, Err
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with dual write, bypass and clear sweep
module regfile_mp #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 64,
    parameter int AW       = 6,
    parameter int NR       = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic         Clk,
    input logic         Rst_n,
    regfile_mp_if.slave bus
);
    localparam logic [0:0]    IDLE    = 1'b0;
    localparam logic [0:0]    SWEEP   = 1'b1;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic             busy, q0, q1, oor;
    logic [WIDTH-1:0] rd_nxt [NR];

    assign busy     = state == SWEEP;
    assign bus.Busy = busy;
    assign q0  = bus.We0 && ({1'b0, bus.Wa0} < DEPTH_W) && !(ZERO_REG != 0 && bus.Wa0 == '0) && !busy;
    assign q1  = bus.We1 && ({1'b0, bus.Wa1} < DEPTH_W) && !(ZERO_REG != 0 && bus.Wa1 == '0) && !busy;
    assign oor = (bus.We0 && {1'b0, bus.Wa0} >= DEPTH_W) || (bus.We1 && {1'b0, bus.Wa1} >= DEPTH_W);

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd_mem;
        assign ra     = bus.Read_reg[g*AW +: AW];
        assign rd_mem = ({1'b0, ra} < DEPTH_W && !(ZERO_REG != 0 && ra == '0)) ? mem[ra] : '0;
        assign rd_nxt[g] = BYPASS == 0        ? rd_mem :
                           q1 && bus.Wa1 == ra ? bus.Wd1 :
                           q0 && bus.Wa0 == ra ? bus.Wd0 :
                           busy && cnt == ra   ? '0 : rd_mem;
    end

    // storage: sweep zeroes one entry per edge, writes only land while idle, port 1 wins
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.En) begin
            if (busy) mem[cnt] <= '0;
            if (q0) mem[bus.Wa0] <= bus.Wd0;
            if (q1) mem[bus.Wa1] <= bus.Wd1;
        end
    end

    // registered read ports
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) bus.Read_data <= '0;
        else if (bus.En)
            for (int i = 0; i < NR; i++) bus.Read_data[i*WIDTH +: WIDTH] <= rd_nxt[i];
    end

    // clear-sweep sequencer: counter stops exactly at DEPTH-1
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.En) begin
            if (!busy) begin
                state <= bus.Clr ? SWEEP : IDLE;
                cnt   <= '0;
            end else if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // sticky out-of-range write flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) bus.Err <= 1'b0;
        else if (bus.En && oor) bus.Err <= 1'b1;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two configurations driven in lockstep and checked against an array model
module tb_regfile_mp;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        run = 1'b0;
    logic        En;
    logic        we0, we1, clr;
    logic [5:0]  wa0, wa1, rr0, rr1;
    logic [63:0] wd0, wd1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int DEP [2] = '{64, 48};
    localparam bit ZR  [2] = '{1'b0, 1'b1};
    localparam bit BY  [2] = '{1'b1, 1'b0};

    logic [63:0] m  [2][64];
    logic [63:0] rd [2][2];
    bit          sw [2];
    int          sc [2];
    bit          er [2];

    regfile_mp_if #(.WIDTH(64), .AW(6), .NR(2)) ia ();
    regfile_mp_if #(.WIDTH(64), .AW(6), .NR(2)) ib ();

    regfile_mp #(.WIDTH(64), .DEPTH(64), .AW(6), .NR(2), .ZERO_REG(0), .BYPASS(1))
        dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ia));
    regfile_mp #(.WIDTH(64), .DEPTH(48), .AW(6), .NR(2), .ZERO_REG(1), .BYPASS(0))
        dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ib));

    assign ia.En = En;  assign ia.Clr = clr; assign ia.Read_reg = {rr1, rr0};
    assign ia.We0 = we0; assign ia.Wa0 = wa0; assign ia.Wd0 = wd0;
    assign ia.We1 = we1; assign ia.Wa1 = wa1; assign ia.Wd1 = wd1;
    assign ib.En = En;  assign ib.Clr = clr; assign ib.Read_reg = {rr1, rr0};
    assign ib.We0 = we0; assign ib.Wa0 = wa0; assign ib.Wd0 = wd0;
    assign ib.We1 = we1; assign ib.Wa1 = wa1; assign ib.Wd1 = wd1;

    always begin
        #5;
        if (run) Clk = ~Clk;
    end

    typedef struct {
        logic        we0;
        logic [5:0]  wa0;
        logic [63:0] wd0;
        logic        we1;
        logic [5:0]  wa1;
        logic [63:0] wd1;
        logic [5:0]  r0, r1;
        logic [63:0] e0, e1;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) m[k][a] = '0;
            rd[k][0] = '0; rd[k][1] = '0;
            sw[k] = 0; sc[k] = 0; er[k] = 0;
        end
    endtask

    task automatic model_update();
        if (En) begin
            for (int k = 0; k < 2; k++) begin
                bit q0, q1;
                int a;
                logic [63:0] v;
                q0 = we0 && int'(wa0) < DEP[k] && !(ZR[k] && wa0 == 0) && !sw[k];
                q1 = we1 && int'(wa1) < DEP[k] && !(ZR[k] && wa1 == 0) && !sw[k];
                if ((we0 && int'(wa0) >= DEP[k]) || (we1 && int'(wa1) >= DEP[k])) er[k] = 1;
                for (int i = 0; i < 2; i++) begin
                    a = (i == 0) ? int'(rr0) : int'(rr1);
                    v = (a < DEP[k] && !(ZR[k] && a == 0)) ? m[k][a] : 64'd0;
                    if (BY[k]) begin
                        if (q1 && int'(wa1) == a) v = wd1;
                        else if (q0 && int'(wa0) == a) v = wd0;
                        else if (sw[k] && sc[k] == a) v = 64'd0;
                    end
                    rd[k][i] = v;
                end
                if (sw[k]) begin
                    m[k][sc[k]] = '0;
                    sc[k]++;
                    if (sc[k] == DEP[k]) begin sw[k] = 0; sc[k] = 0; end
                end else begin
                    if (q0) m[k][wa0] = wd0;
                    if (q1) m[k][wa1] = wd1;
                    if (clr) begin sw[k] = 1; sc[k] = 0; end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("A.rd0", ia.Read_data[63:0], rd[0][0]);
        chk("A.rd1", ia.Read_data[127:64], rd[0][1]);
        chk("A.busy", 64'(ia.Busy), 64'(sw[0]));
        chk("A.err", 64'(ia.Err), 64'(er[0]));
        chk("B.rd0", ib.Read_data[63:0], rd[1][0]);
        chk("B.rd1", ib.Read_data[127:64], rd[1][1]);
        chk("B.busy", 64'(ib.Busy), 64'(sw[1]));
        chk("B.err", 64'(ib.Err), 64'(er[1]));
    endtask

    task automatic step();
        model_update();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        En = 1; we0 = 0; we1 = 0; clr = 0;
    endtask

    task automatic fill_all();
        for (int a = 0; a < 64; a++) begin
            we0 = 1; wa0 = 6'(a); wd0 = 64'(a) + 64'h100;
            rr0 = 6'(a); rr1 = 6'(63 - a);
            step();
        end
        idle_in();
    endtask

    initial begin
        int ca, cb;
        idle_in();
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rr0 = 0; rr1 = 0;
        #2 Rst_n = 1'b0;
        #3;
        chk("rst.A.rd0", ia.Read_data[63:0], 64'd0);
        chk("rst.A.rd1", ia.Read_data[127:64], 64'd0);
        chk("rst.A.busy", 64'(ia.Busy), 64'd0);
        chk("rst.A.err", 64'(ia.Err), 64'd0);
        chk("rst.B.rd0", ib.Read_data[63:0], 64'd0);
        chk("rst.B.rd1", ib.Read_data[127:64], 64'd0);
        chk("rst.B.busy", 64'(ib.Busy), 64'd0);
        chk("rst.B.err", 64'(ib.Err), 64'd0);
        model_reset();
        run = 1'b1;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        for (int a = 0; a < 64; a++) begin
            rr0 = 6'(a); rr1 = 6'(63 - a);
            step();
        end

        tv[0] = '{1, 5,  64'hDEADBEEF_00000001, 0, 0,  0,       5,  0,  64'hDEADBEEF_00000001, 64'd0};
        tv[1] = '{0, 0,  0,                     0, 0,  0,       5,  5,  64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001};
        tv[2] = '{1, 10, 64'h11,                1, 10, 64'h22,  10, 5,  64'h22, 64'hDEADBEEF_00000001};
        tv[3] = '{0, 0,  0,                     0, 0,  0,       10, 10, 64'h22, 64'h22};
        tv[4] = '{1, 0,  64'hFF,                0, 0,  0,       0,  10, 64'hFF, 64'h22};
        tv[5] = '{0, 0,  0,                     1, 50, 64'hABC, 50, 0,  64'hABC, 64'hFF};
        tv[6] = '{1, 7,  64'd1,                 1, 8,  64'd2,   7,  8,  64'd1, 64'd2};
        tv[7] = '{0, 0,  0,                     0, 0,  0,       8,  7,  64'd2, 64'd1};
        for (int j = 0; j < 8; j++) begin
            we0 = tv[j].we0; wa0 = tv[j].wa0; wd0 = tv[j].wd0;
            we1 = tv[j].we1; wa1 = tv[j].wa1; wd1 = tv[j].wd1;
            rr0 = tv[j].r0;  rr1 = tv[j].r1;
            step();
            chk($sformatf("vec%0d.A.rd0", j), ia.Read_data[63:0], tv[j].e0);
            chk($sformatf("vec%0d.A.rd1", j), ia.Read_data[127:64], tv[j].e1);
        end
        idle_in();

        rr0 = 0; rr1 = 50;
        step();
        chk("zero.B.rd0", ib.Read_data[63:0], 64'd0);
        chk("oor.B.rd1", ib.Read_data[127:64], 64'd0);
        chk("oor.B.err", 64'(ib.Err), 64'd1);
        chk("zero.A.rd0", ia.Read_data[63:0], 64'hFF);
        we0 = 1; wa0 = 5; wd0 = 64'h1234; rr0 = 5;
        step();
        chk("nobyp.B.old", ib.Read_data[63:0], 64'hDEADBEEF_00000001);
        chk("byp.A.new", ia.Read_data[63:0], 64'h1234);
        idle_in();
        step();
        chk("nobyp.B.new", ib.Read_data[63:0], 64'h1234);

        for (int t = 0; t < 400; t++) begin
            En  = $urandom_range(0, 9) != 0;
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = 6'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 6'($urandom);
            wd0 = {$urandom, $urandom}; wd1 = {$urandom, $urandom};
            rr0 = ($urandom_range(0, 2) == 0) ? wa0 : 6'($urandom);
            rr1 = ($urandom_range(0, 2) == 0) ? wa1 : 6'($urandom);
            clr = $urandom_range(0, 49) == 0;
            step();
        end
        idle_in();
        for (int t = 0; t < 200 && (ia.Busy || ib.Busy); t++) step();
        chk("idle_wait", 64'(ia.Busy | ib.Busy), 64'd0);

        fill_all();
        clr = 1;
        step();
        clr = 0;
        ca = int'(ia.Busy); cb = int'(ib.Busy);
        for (int t = 0; t < 200 && (ia.Busy || ib.Busy); t++) begin
            we0 = (t == 10); wa0 = 3; wd0 = 64'hFFFF;
            rr0 = 6'(t); rr1 = 6'(t + 1);
            step();
            ca += int'(ia.Busy); cb += int'(ib.Busy);
        end
        chk("sweep.A.len", 64'(ca), 64'd64);
        chk("sweep.B.len", 64'(cb), 64'd48);
        idle_in();
        rr0 = 3; rr1 = 63;
        step();
        chk("sweep.A.drop", ia.Read_data[63:0], 64'd0);
        chk("sweep.A.last", ia.Read_data[127:64], 64'd0);
        chk("sweep.A.err", 64'(ia.Err), 64'd0);

        fill_all();
        clr = 1;
        step();
        clr = 0;
        ca = int'(ia.Busy); cb = int'(ib.Busy);
        for (int t = 0; t < 200 && (ia.Busy || ib.Busy); t++) begin
            En = !(t >= 5 && t < 8);
            rr0 = 6'($urandom); rr1 = 6'(t);
            step();
            ca += int'(ia.Busy); cb += int'(ib.Busy);
        end
        chk("stall.A.len", 64'(ca), 64'd67);
        chk("stall.B.len", 64'(cb), 64'd51);
        idle_in();

        fill_all();
        clr = 1;
        step();
        clr = 0;
        repeat (20) step();
        #2 Rst_n = 1'b0;
        #1;
        chk("abort.A.busy", 64'(ia.Busy), 64'd0);
        chk("abort.B.busy", 64'(ib.Busy), 64'd0);
        chk("abort.A.rd0", ia.Read_data[63:0], 64'd0);
        chk("abort.B.err", 64'(ib.Err), 64'd0);
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            rr0 = 6'(a); rr1 = 6'(63 - a);
            step();
        end
        for (int a = 0; a < 4; a++) begin
            we0 = 1; wa0 = 6'(a); wd0 = 64'hA0 + 64'(a);
            step();
        end
        idle_in();
        clr = 1; rr0 = 1;
        step();
        clr = 0;
        ca = int'(ia.Busy);
        for (int t = 0; t < 200 && ia.Busy; t++) begin
            rr0 = 6'(t); rr1 = 6'(t + 1);
            step();
            ca += int'(ia.Busy);
        end
        chk("fresh.A.len", 64'(ca), 64'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file. It generalises the team's 64×64 register file to configurable width, depth and read-port count, with two write ports, optional write-to-read bypass, an optional hardwired zero register, and a multi-cycle clear sweep. It sits between the decode stage (read addresses) and writeback (two write channels) of the datapath.

## Interface
- WIDTH, 64, data width in bits
- DEPTH, 64, number of entries
- AW, 6, address width; must satisfy 2^AW >= DEPTH
- NR, 2, number of read ports
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes
- BYPASS, 1, when 1, same-edge writes are forwarded to the read outputs

- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- En  in  1  global enable; when 0, no state changes and outputs hold
- Read_reg  in  NR*AW  read addresses; port i is bits [i*AW +: AW]
- Read_data  out  NR*WIDTH  registered read data; port i is bits [i*WIDTH +: WIDTH]
- We0, We1  in  1  write enables for write ports 0 and 1
- Wa0, Wa1  in  AW  write addresses
- Wd0, Wd1  in  WIDTH  write data
- Clr  in  1  start a clear sweep
- Busy  out  1  a clear sweep is in progress
- Err  out  1  sticky flag for an out-of-range write

## Operation
- **Reset:** Rst_n low asynchronously sets the following, with no clock needed:
  - all entries, Read_data, Busy and Err to 0
  - the FSM to IDLE and the sweep counter to 0
- **En:** every action below happens only on a rising Clk edge with En=1. With En=0, the array, Read_data, the FSM, the counter and Err all hold.
- **Write port p qualifies when all hold:**
  - Wep=1
  - Wap < DEPTH
  - not (ZERO_REG=1 and Wap=0)
  - Busy=0
- **Write conflicts:** if both ports qualify with the same address, port 1's data is written.
- **Out-of-range write:** Wep=1 with Wap >= DEPTH drops the write and sets Err. Err stays set until reset. Writes dropped because Busy=1 or because of ZERO_REG do not set Err.
- **Read port i:** Read_data[i] is loaded with the entry at Read_reg[i] on each enabled edge. It reads 0 in these cases:
  - the address is >= DEPTH
  - ZERO_REG=1 and the address is 0
- **Bypass with BYPASS=1:** if a qualifying write targets Read_reg[i] on the same edge, Read_data[i] takes the written data. If both write ports hit, port 1's data is used. A sweep clear of that entry on the same edge forwards 0.
- **Bypass with BYPASS=0:** reads return the pre-edge contents.
- **FSM states:** IDLE, SWEEP.
  - IDLE → SWEEP on an enabled edge with Clr=1. The counter loads 0.
  - In SWEEP, each enabled edge zeroes entry[counter] and increments the counter. After entry DEPTH-1 is cleared, the FSM returns to IDLE and the counter resets to 0.
  - Clr is ignored while in SWEEP.
  - Busy = (state == SWEEP).
- **Reads during a sweep** continue and return the current contents, including entries already zeroed.
- **Counter width:** the counter is AW bits wide and compares against DEPTH-1 exactly, so a non-power-of-two DEPTH never wraps into illegal entries.

## Timing
- Read latency is 1 cycle: an address presented before edge k gives data valid after edge k.
- A write at edge k:
  - appears in Read_data at edge k when BYPASS=1
  - appears at edge k+1 when BYPASS=0
- A sweep started by Clr at edge k:
  - Busy rises after edge k
  - entry j is cleared at edge k+1+j
  - Busy falls after edge k+DEPTH
  - Total is DEPTH enabled cycles; En=0 cycles stretch it.
- Err rises after the edge of the offending write.
- Reset mid-sweep aborts the sweep immediately: Busy=0, all entries 0.
- A Clr and a write on the same IDLE edge: the write completes, and the sweep clears that entry later.

## Test plan
- **Reset defaults:** hold Rst_n low with Clk stopped → Read_data=0, Busy=0, Err=0. Then read all DEPTH addresses → all return 0.
- **Write/read with BYPASS=1:** write 0xDEADBEEF_00000001 to entry 5 while Read_reg[0]=5 on the same edge → Read_data[0]=0xDEADBEEF_00000001 after that edge. Repeat with BYPASS=0 → old value 0 first, new value one edge later.
- **Write conflict:** We0 and We1 both target entry 10, with Wd0=0x11 and Wd1=0x22 → entry 10 reads 0x22. With ZERO_REG=1, write 0xFF to entry 0 → it reads 0 and Err stays 0.
- **Out-of-range write:** with DEPTH=48 and AW=6, write address 50 → Err=1, no entry changes, a read of address 50 returns 0. Err stays 1 until Rst_n.
- **Clear sweep:** fill all entries with nonzero data, pulse Clr at edge k:
  - Busy is high for exactly DEPTH cycles
  - entry j reads 0 from edge k+1+j onward
  - a write during Busy is dropped and does not set Err
  - toggling En=0 for 3 cycles mid-sweep extends Busy by 3 cycles
- **Reset mid-sweep:** assert Rst_n low asynchronously at sweep step 20 → Busy falls immediately and all entries read 0. A Clr after release starts a fresh sweep from entry 0.
